// File: rtl/ones_count_pkg.sv
// Shared types and sizing helpers for the ones-count window accumulator.
//   CNT_W_DEFAULT : width of a count sample from the 15-input ones counter
//   state_t       : accumulator FSM states {ACC, HOLD}
//   sum_width()   : sum width that holds 15*window without overflow
package ones_count_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int unsigned sum_width(input int unsigned window);
    return CNT_W_DEFAULT + $clog2(window);
  endfunction

endpackage

// File: rtl/ones_count_win_ctr.sv
// Sample counter 0..WINDOW-1 for the window accumulator.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (priority over inc)
//   inc      : count one accepted sample; wraps to 0 after WINDOW-1
//   last     : counter is at WINDOW-1, i.e. the next inc completes the window
module ones_count_win_ctr #(
  parameter int unsigned WINDOW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int unsigned CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(WINDOW - 1));

  // Wrap only on window completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ones_count_window_acc.sv
// Accumulates WINDOW accepted ones-count samples into a window sum and presents
// it on a valid/ready handshake.
//   clk, rst             : clock, async active-high reset
//   clr                  : synchronous window abort; drops the same-cycle sample
//   in_valid/in_count    : incoming count sample
//   in_ready             : high in ACC, low while a result is held
//   out_valid/out_sum    : completed window sum, held until out_ready
//   out_ready            : consumer takes the sum
//   peak_out             : max sample of the window (only with ONES_ACC_PEAK_EN)
// Optional feature macro: ONES_ACC_PEAK_EN
module ones_count_window_acc
  import ones_count_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SUM_W  = sum_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
`ifdef ONES_ACC_PEAK_EN
  output logic [CNT_W-1:0] peak_out,
`endif
  input  logic             out_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [SUM_W-1:0] acc;
  logic             accept;
  logic             last;

  // in_ready decodes directly from the state register.
  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready && !clr;

  ones_count_win_ctr #(
    .WINDOW (WINDOW)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (accept),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr forces ACC from either state.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && last) state_nxt = HOLD;
      HOLD:    if (out_ready)      state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (clr) state_nxt = ACC;
  end

  // Accumulator and result registers; out_sum is only rewritten on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_sum   <= acc + SUM_W'(in_count);
        out_valid <= 1'b1;
        acc       <= '0;
      end else begin
        acc <= acc + SUM_W'(in_count);
      end
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ONES_ACC_PEAK_EN
  logic [CNT_W-1:0] peak;
  logic [CNT_W-1:0] peak_upd;

  assign peak_upd = (in_count > peak) ? in_count : peak;

  // Running max restarts each window; the window's max is latched with out_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak     <= '0;
      peak_out <= '0;
    end else if (clr) begin
      peak     <= '0;
      peak_out <= '0;
    end else if (accept) begin
      if (last) begin
        peak_out <= peak_upd;
        peak     <= '0;
      end else begin
        peak <= peak_upd;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ones_count_window_acc.sv
// Directed bench for ones_count_window_acc: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_ones_count_window_acc;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic [CNT_W-1:0] in_count;
  logic             in_ready;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic             out_ready;
`ifdef ONES_ACC_PEAK_EN
  logic [CNT_W-1:0] peak_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ones_count_window_acc dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
`ifdef ONES_ACC_PEAK_EN
    .peak_out  (peak_out),
`endif
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle; called and returns at a falling edge.
  task automatic push(input logic [CNT_W-1:0] c);
    in_valid = 1'b1;
    in_count = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_n(input logic [CNT_W-1:0] c, input int n);
    for (int i = 0; i < n; i++) push(c);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: eight back-to-back 15s
    push_n(4'd15, 7);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    push(4'd15);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum", 32'(out_sum), 32'd120);
    chk("t1_in_ready", 32'(in_ready), 32'd0);

    // 3: hold under backpressure while samples are offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_count  = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_sum", 32'(out_sum), 32'd120);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    chk("t3_released_valid", 32'(out_valid), 32'd0);
    chk("t3_released_in_ready", 32'(in_ready), 32'd1);

    // 2: samples 0..7 with gaps of 0..3 cycles; window starts from zero
    for (int i = 0; i < 8; i++) begin
      push(4'(i));
      if (i == 6) chk("t2_not_yet_valid", 32'(out_valid), 32'd0);
      if (i < 7) repeat (i % 4) @(negedge clk);
    end
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_sum", 32'(out_sum), 32'd28);
    release_result();

    // 4: clr mid-window drops its sample and restarts the window
    push_n(4'd5, 3);
    clr = 1'b1; in_valid = 1'b1; in_count = 4'd5;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("t4_clr_valid", 32'(out_valid), 32'd0);
    chk("t4_clr_in_ready", 32'(in_ready), 32'd1);
    push_n(4'd1, 7);
    chk("t4_not_yet_valid", 32'(out_valid), 32'd0);
    push(4'd1);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_sum", 32'(out_sum), 32'd8);

    // clr during HOLD discards the pending result
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_hold_clr_valid", 32'(out_valid), 32'd0);
    chk("t4_hold_clr_in_ready", 32'(in_ready), 32'd1);

    // 5: asynchronous reset mid-window
    push_n(4'd2, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_sum", 32'(out_sum), 32'd0);
    chk("t5_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_n(4'd2, 8);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_sum", 32'(out_sum), 32'd16);
    release_result();

`ifdef ONES_ACC_PEAK_EN
    // 6: peak tracking across two windows
    push(4'd3); push(4'd9); push(4'd4); push(4'd0);
    push(4'd15); push(4'd1); push(4'd2); push(4'd7);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_sum", 32'(out_sum), 32'd41);
    chk("t6_peak", 32'(peak_out), 32'd15);
    release_result();
    push_n(4'd1, 8);
    chk("t6_sum2", 32'(out_sum), 32'd8);
    chk("t6_peak2", 32'(peak_out), 32'd1);
    release_result();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
